// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external 64-bit ALU between NUM_REQ requesters.
// Optional transaction counter port txn_cnt is enabled by defining ALU_ARB_TXN_CNT_EN.
module alu_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDW     = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*64-1:0] req_a,
    input  logic [NUM_REQ*64-1:0] req_b,
    input  logic [NUM_REQ-1:0]    req_cin,
    input  logic [NUM_REQ*2-1:0]  req_op,
    output logic [63:0]           alu_a,
    output logic [63:0]           alu_b,
    output logic                  alu_cin,
    output logic [1:0]            alu_op,
    input  logic [63:0]           alu_s,
    input  logic                  alu_cout,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [63:0]           rsp_s,
    output logic                  rsp_cout
`ifdef ALU_ARB_TXN_CNT_EN
    ,
    output logic [31:0]           txn_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] id_q, id_d;
    logic [63:0]    a_q, a_d, b_q, b_d;
    logic           cin_q, cin_d;
    logic [1:0]     op_q, op_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic [63:0]    rsp_s_q, rsp_s_d;
    logic           rsp_cout_q, rsp_cout_d;

    logic               grant_vld;
    logic [IDW-1:0]     grant_id;
    logic [NUM_REQ-1:0] grant_oh;
    logic [63:0]        sel_a, sel_b;
    logic               sel_cin;
    logic [1:0]         sel_op;

    // Pass 0 scans rr_ptr..NUM_REQ-1, pass 1 wraps to 0..rr_ptr-1.
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        grant_oh  = '0;
        sel_a     = '0;
        sel_b     = '0;
        sel_cin   = 1'b0;
        sel_op    = '0;
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!grant_vld && req_valid[i] && ((pass == 0) == (i >= int'(rr_ptr_q)))) begin
                    grant_vld   = 1'b1;
                    grant_id    = IDW'(i);
                    grant_oh[i] = 1'b1;
                    sel_a       = req_a[64*i +: 64];
                    sel_b       = req_b[64*i +: 64];
                    sel_cin     = req_cin[i];
                    sel_op      = req_op[2*i +: 2];
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        a_d         = a_q;
        b_d         = b_q;
        cin_d       = cin_q;
        op_d        = op_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_s_d     = rsp_s_q;
        rsp_cout_d  = rsp_cout_q;
        req_ready   = '0;
        alu_a       = '0;
        alu_b       = '0;
        alu_cin     = 1'b0;
        alu_op      = '0;
        case (state_q)
            IDLE: begin
                // Gate with rst_n so no grant is advertised while reset is held.
                if (grant_vld && rst_n) begin
                    req_ready = grant_oh;
                    id_d      = grant_id;
                    a_d       = sel_a;
                    b_d       = sel_b;
                    cin_d     = sel_cin;
                    op_d      = sel_op;
                    rr_ptr_d  = (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                alu_a       = a_q;
                alu_b       = b_q;
                alu_cin     = cin_q;
                alu_op      = op_q;
                rsp_s_d     = alu_s;
                rsp_cout_d  = alu_cout;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            cin_q       <= 1'b0;
            op_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_s_q     <= '0;
            rsp_cout_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cin_q       <= cin_d;
            op_q        <= op_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_s_q     <= rsp_s_d;
            rsp_cout_q  <= rsp_cout_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_s     = rsp_s_q;
    assign rsp_cout  = rsp_cout_q;

`ifdef ALU_ARB_TXN_CNT_EN
    logic [31:0] txn_cnt_q, txn_cnt_d;

    always_comb begin
        txn_cnt_d = txn_cnt_q;
        if (rsp_valid_q && rsp_ready && (txn_cnt_q != 32'hFFFF_FFFF)) begin
            txn_cnt_d = txn_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txn_cnt_q <= '0;
        end else begin
            txn_cnt_q <= txn_cnt_d;
        end
    end

    assign txn_cnt = txn_cnt_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU (op 0 add, 1 and, 2 or, 3 xor).
// Counter checks are compiled only when ALU_ARB_TXN_CNT_EN is defined.
module tb_alu_arbiter;

    localparam int NUM_REQ = 2;
    localparam int IDW     = 1;

    logic                  clk;
    logic                  rst_n;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*64-1:0] req_a;
    logic [NUM_REQ*64-1:0] req_b;
    logic [NUM_REQ-1:0]    req_cin;
    logic [NUM_REQ*2-1:0]  req_op;
    logic [63:0]           alu_a, alu_b, alu_s;
    logic                  alu_cin, alu_cout;
    logic [1:0]            alu_op;
    logic                  rsp_valid, rsp_ready, rsp_cout;
    logic [IDW-1:0]        rsp_id;
    logic [63:0]           rsp_s;
`ifdef ALU_ARB_TXN_CNT_EN
    logic [31:0]           txn_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    alu_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .req_op    (req_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_cin   (alu_cin),
        .alu_op    (alu_op),
        .alu_s     (alu_s),
        .alu_cout  (alu_cout),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_s     (rsp_s),
        .rsp_cout  (rsp_cout)
`ifdef ALU_ARB_TXN_CNT_EN
        ,
        .txn_cnt   (txn_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [64:0] alu_sum;
    always_comb begin
        alu_sum  = {1'b0, alu_a} + {1'b0, alu_b} + {64'd0, alu_cin};
        alu_s    = '0;
        alu_cout = 1'b0;
        case (alu_op)
            2'b00: begin alu_s = alu_sum[63:0]; alu_cout = alu_sum[64]; end
            2'b01: alu_s = alu_a & alu_b;
            2'b10: alu_s = alu_a | alu_b;
            default: alu_s = alu_a ^ alu_b;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic set_req(input int id, input logic [63:0] a, input logic [63:0] b,
                           input logic cin, input logic [1:0] op);
        req_a[64*id +: 64] = a;
        req_b[64*id +: 64] = b;
        req_cin[id]        = cin;
        req_op[2*id +: 2]  = op;
    endtask

    // Drives one request to completion; lat is cycles from the ready cycle to rsp_valid, -1 on timeout.
    task automatic do_txn(input int id, input logic [63:0] a, input logic [63:0] b,
                          input logic cin, input logic [1:0] op,
                          output logic [63:0] s, output logic cout,
                          output logic [IDW-1:0] rid, output int lat);
        int w;
        set_req(id, a, b, cin, op);
        req_valid     = '0;
        req_valid[id] = 1'b1;
        rsp_ready     = 1'b1;
        s   = '0;
        cout = 1'b0;
        rid = '0;
        lat = -1;
        w   = 0;
        while (!req_ready[id] && w < 20) begin
            tick();
            w++;
        end
        if (req_ready[id]) begin
            tick();
            req_valid = '0;
            w = 1;
            while (!rsp_valid && w < 10) begin
                tick();
                w++;
            end
            if (rsp_valid) begin
                lat  = w;
                s    = rsp_s;
                cout = rsp_cout;
                rid  = rsp_id;
                tick();
            end
        end
        req_valid = '0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = '1;
        rsp_ready = 1'b1;
        #3;
        n_checks++;
        if (req_ready !== 2'b00) begin n_errors++; $display("FAIL reset_req_ready: got %b want 00", req_ready); end
        n_checks++;
        if ({rsp_valid, rsp_id, rsp_cout} !== 3'b000) begin n_errors++; $display("FAIL reset_rsp_ctl: got %b want 000", {rsp_valid, rsp_id, rsp_cout}); end
        n_checks++;
        if (rsp_s !== 64'h0) begin n_errors++; $display("FAIL reset_rsp_s: got %h want 0", rsp_s); end
        n_checks++;
        if ({alu_a, alu_b, alu_cin, alu_op} !== 131'h0) begin n_errors++; $display("FAIL reset_alu: got a=%h b=%h cin=%b op=%b want all 0", alu_a, alu_b, alu_cin, alu_op); end
        req_valid = '0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        set_req(0, 64'h5, 64'h3, 1'b0, 2'b00);
        req_valid = 2'b01;
        rsp_ready = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 2'b01) begin n_errors++; $display("FAIL single_ready: got %b want 01", req_ready); end
        tick();
        req_valid = '0;
        n_checks++;
        if (alu_a !== 64'h5 || alu_b !== 64'h3 || alu_cin !== 1'b0 || alu_op !== 2'b00)
            begin n_errors++; $display("FAIL single_alu_drive: got a=%h b=%h cin=%b op=%b want 5 3 0 00", alu_a, alu_b, alu_cin, alu_op); end
        n_checks++;
        if (req_ready !== 2'b00 || rsp_valid !== 1'b0) begin n_errors++; $display("FAIL single_exec_ctl: got ready=%b rsp_valid=%b want 00 0", req_ready, rsp_valid); end
        tick();
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_s !== 64'h8 || rsp_cout !== 1'b0 || rsp_id !== 1'b0)
            begin n_errors++; $display("FAIL single_rsp: got v=%b s=%h c=%b id=%0d want 1 8 0 0", rsp_valid, rsp_s, rsp_cout, rsp_id); end
        n_checks++;
        if (alu_a !== 64'h0) begin n_errors++; $display("FAIL single_alu_idle: got %h want 0", alu_a); end
        tick();
        n_checks++;
        if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL single_rsp_clear: got %b want 0", rsp_valid); end
    endtask

    task automatic test_carry();
        logic [63:0]    s;
        logic           c;
        logic [IDW-1:0] rid;
        int             lat;
        do_txn(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 2'b00, s, c, rid, lat);
        n_checks++;
        if (s !== 64'h0 || c !== 1'b1 || rid !== 1'b1 || lat != 2)
            begin n_errors++; $display("FAIL carry_out: got s=%h c=%b id=%0d lat=%0d want 0 1 1 2", s, c, rid, lat); end
    endtask

    task automatic test_op_passthrough();
        logic [63:0]    s;
        logic           c;
        logic [IDW-1:0] rid;
        int             lat;
        do_txn(0, 64'h00F0, 64'h00FF, 1'b1, 2'b11, s, c, rid, lat);
        n_checks++;
        if (s !== 64'h000F || c !== 1'b0 || rid !== 1'b0 || lat != 2)
            begin n_errors++; $display("FAIL op_xor: got s=%h c=%b id=%0d lat=%0d want 000f 0 0 2", s, c, rid, lat); end
        do_txn(1, 64'h10, 64'h20, 1'b1, 2'b00, s, c, rid, lat);
        n_checks++;
        if (s !== 64'h31 || c !== 1'b0 || rid !== 1'b1)
            begin n_errors++; $display("FAIL cin_add: got s=%h c=%b id=%0d want 31 0 1", s, c, rid); end
    endtask

    task automatic test_round_robin();
        logic [NUM_REQ-1:0] exp_oh;
        logic [63:0]        exp_s;
        apply_reset();
        set_req(0, 64'd10, 64'd1, 1'b0, 2'b00);
        set_req(1, 64'd20, 64'd2, 1'b0, 2'b00);
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        #1;
        for (int g = 0; g < 4; g++) begin
            exp_oh = (g % 2 == 0) ? 2'b01 : 2'b10;
            exp_s  = (g % 2 == 0) ? 64'd11 : 64'd22;
            n_checks++;
            if (req_ready !== exp_oh) begin n_errors++; $display("FAIL rr_grant%0d: got %b want %b", g, req_ready, exp_oh); end
            tick();
            tick();
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== IDW'(g % 2) || rsp_s !== exp_s)
                begin n_errors++; $display("FAIL rr_rsp%0d: got v=%b id=%0d s=%0d want 1 %0d %0d", g, rsp_valid, rsp_id, rsp_s, g % 2, exp_s); end
            tick();
        end
        req_valid = '0;
    endtask

    task automatic test_back_pressure();
        set_req(0, 64'd7, 64'd9, 1'b0, 2'b00);
        set_req(1, 64'd100, 64'd5, 1'b0, 2'b00);
        req_valid = 2'b01;
        rsp_ready = 1'b0;
        #1;
        n_checks++;
        if (req_ready !== 2'b01) begin n_errors++; $display("FAIL bp_grant: got %b want 01", req_ready); end
        tick();
        req_valid = 2'b10;
        tick();
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_s !== 64'd16 || rsp_id !== 1'b0 || req_ready !== 2'b00 || alu_a !== 64'h0)
                begin n_errors++; $display("FAIL bp_hold%0d: got v=%b s=%0d id=%0d ready=%b alu_a=%h want 1 16 0 00 0", k, rsp_valid, rsp_s, rsp_id, req_ready, alu_a); end
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 2'b00) begin n_errors++; $display("FAIL bp_ready_in_resp: got %b want 00", req_ready); end
        tick();
        n_checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 2'b10) begin n_errors++; $display("FAIL bp_resume: got v=%b ready=%b want 0 10", rsp_valid, req_ready); end
        tick();
        req_valid = '0;
        tick();
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_s !== 64'd105)
            begin n_errors++; $display("FAIL bp_second: got v=%b id=%0d s=%0d want 1 1 105", rsp_valid, rsp_id, rsp_s); end
        tick();
    endtask

    task automatic test_reset_mid();
        set_req(0, 64'd40, 64'd2, 1'b0, 2'b00);
        set_req(1, 64'd50, 64'd3, 1'b0, 2'b00);
        req_valid = 2'b01;
        rsp_ready = 1'b1;
        #1;
        tick();
        req_valid = 2'b11;
        #2;
        n_checks++;
        if (alu_a !== 64'd40) begin n_errors++; $display("FAIL rm_in_exec: got alu_a=%0d want 40", alu_a); end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({alu_a, alu_b, alu_cin, alu_op} !== 131'h0 || req_ready !== 2'b00)
            begin n_errors++; $display("FAIL rm_async_alu: got a=%h b=%h ready=%b want 0 0 00", alu_a, alu_b, req_ready); end
        n_checks++;
        if (rsp_valid !== 1'b0 || rsp_s !== 64'h0 || rsp_id !== 1'b0 || rsp_cout !== 1'b0)
            begin n_errors++; $display("FAIL rm_async_rsp: got v=%b s=%h id=%0d c=%b want 0 0 0 0", rsp_valid, rsp_s, rsp_id, rsp_cout); end
        req_valid = '0;
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL rm_no_rsp%0d: got %b want 0", k, rsp_valid); end
        end
        req_valid = 2'b11;
        #1;
        n_checks++;
        if (req_ready !== 2'b01) begin n_errors++; $display("FAIL rm_next_grant: got %b want 01", req_ready); end
        tick();
        req_valid = '0;
        tick();
        tick();
    endtask

`ifdef ALU_ARB_TXN_CNT_EN
    task automatic test_txn_cnt();
        logic [63:0]    s;
        logic           c;
        logic [IDW-1:0] rid;
        int             lat;
        apply_reset();
        n_checks++;
        if (txn_cnt !== 32'd0) begin n_errors++; $display("FAIL cnt_reset: got %0d want 0", txn_cnt); end
        for (int k = 0; k < 4; k++) do_txn(k % 2, 64'(k), 64'd1, 1'b0, 2'b00, s, c, rid, lat);
        n_checks++;
        if (txn_cnt !== 32'd4) begin n_errors++; $display("FAIL cnt_four: got %0d want 4", txn_cnt); end
        force dut.txn_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.txn_cnt_q;
        do_txn(0, 64'd1, 64'd1, 1'b0, 2'b00, s, c, rid, lat);
        n_checks++;
        if (txn_cnt !== 32'hFFFF_FFFF) begin n_errors++; $display("FAIL cnt_saturate: got %h want ffffffff", txn_cnt); end
    endtask
`endif

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_cin   = '0;
        req_op    = '0;
        rsp_ready = 1'b0;
        test_reset();
        test_single();
        test_carry();
        test_op_passthrough();
        test_round_robin();
        test_back_pressure();
        test_reset_mid();
`ifdef ALU_ARB_TXN_CNT_EN
        test_txn_cnt();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one 64-bit ripple ALU (`alu64bit`, 2-bit op, carry in/out) between NUM_REQ requesters.
- Each requester uses a valid/ready handshake. Grants are round-robin.
- The block registers the operands, drives the ALU for one cycle, then holds the result on a response port tagged with the requester ID.
- It sits between issue logic and the single shared ALU instance.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- IDW, $clog2(NUM_REQ) with a minimum of 1, width of the requester ID.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  in  NUM_REQ*64  operand A; requester i uses bits [64i+63:64i].
- req_b  in  NUM_REQ*64  operand B, same packing as req_a.
- req_cin  in  NUM_REQ  carry in per requester.
- req_op  in  NUM_REQ*2  ALU op per requester; passed through uninterpreted.
- alu_a  out  64  to ALU input a.
- alu_b  out  64  to ALU input b.
- alu_cin  out  1  to ALU cin.
- alu_op  out  2  to ALU op.
- alu_s  in  64  ALU result s.
- alu_cout  in  1  ALU carry out.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts the result.
- rsp_id  out  IDW  index of the requester that owns the result.
- rsp_s  out  64  registered ALU result.
- rsp_cout  out  1  registered carry out.

Behaviour:
- **Reset:** on rst_n low (asynchronous), the FSM goes to IDLE and the round-robin pointer rr_ptr goes to 0. The following are forced to 0: req_ready, rsp_valid, rsp_id, rsp_s, rsp_cout, alu_a, alu_b, alu_cin, alu_op. Reset mid-operation drops the in-flight transaction with no response.
- **FSM states:** IDLE, EXEC, RESP.
- **IDLE:**
  - The grant is the first i with req_valid[i]=1, searching from rr_ptr upward with wrap-around modulo NUM_REQ.
  - req_ready[grant]=1 is combinational in the same cycle; every other req_ready bit is 0. If no request is valid, req_ready=0 and the FSM stays in IDLE.
  - On the grant edge: latch the granted a, b, cin, op and the ID into operand registers; set rr_ptr=(grant+1) mod NUM_REQ; move to EXEC.
- **EXEC:**
  - alu_a/alu_b/alu_cin/alu_op are driven from the operand registers; they are zero in every other state.
  - req_ready=0.
  - On the next edge: capture alu_s into rsp_s and alu_cout into rsp_cout, set rsp_valid=1, move to RESP.
- **RESP:**
  - rsp_valid=1. rsp_s, rsp_cout and rsp_id are held stable until rsp_ready=1.
  - On the edge where rsp_valid && rsp_ready: clear rsp_valid and return to IDLE.
  - req_ready=0 throughout RESP; there is no overlap or pipelining.
- **Latency:** accept at edge N gives rsp_valid high from edge N+2. The minimum issue interval is 3 cycles.
- **Starvation:** a requester holding req_valid is granted within NUM_REQ grants.
- **Requester rules:**
  - A requester must hold its request fields stable while req_valid=1 and not yet accepted.
  - Deasserting req_valid before acceptance is allowed; that request is simply not granted.
  - The arbiter samples operands only on the accept edge.
- **Widths:** 64-bit operands and result. The carry out is reported separately; there is no overflow flag. The op encoding is the ALU's and is not decoded here.

Optional Feature:
- Macro: ALU_ARB_TXN_CNT_EN.
- When defined:
  - Adds output port txn_cnt [31:0], reset to 0.
  - It increments on each rsp_valid && rsp_ready handshake and saturates at 32'hFFFF_FFFF.
- When undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- **Single request:** req 0 only, a=64'h5, b=64'h3, cin=0, op=add encoding. Expect req_ready[0] in that cycle, alu_* driven one cycle later, then rsp_valid with rsp_s=64'h8, rsp_cout=0, rsp_id=0 at accept+2.
- **Carry out:** a=64'hFFFF_FFFF_FFFF_FFFF, b=64'h1, cin=0, add. Expect rsp_s=0, rsp_cout=1.
- **Round-robin:** NUM_REQ=2, both valid continuously, rsp_ready=1. Expect grant order 0,1,0,1 and rsp_id following the same sequence, one result every 3 cycles.
- **Back-pressure:** hold rsp_ready=0 for 5 cycles after rsp_valid. Expect rsp_s/rsp_id stable, req_ready=0 throughout, acceptance resumes the cycle after the handshake.
- **Reset mid-operation:** assert rst_n=0 asynchronously during EXEC. Expect all outputs 0 immediately, no response after release, and the next grant goes to requester 0.
- **Counter with ALU_ARB_TXN_CNT_EN:** 4 completed handshakes give txn_cnt=4. Preloading the counter to the maximum by force and completing one more handshake leaves it at 32'hFFFF_FFFF.
